// File: rtl/axis_src_pkg.sv
// Shared types and field layout for the framed AXI-Stream ramp source.
package axis_src_pkg;

   localparam int TDATA_W  = 64;
   localparam int IDX_LSB  = 0;
   localparam int IDX_MSB  = 31;
   localparam int RAMP_LSB = 32;
   localparam int RAMP_MSB = 63;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_e;

endpackage

// File: rtl/axis_pattern_source.sv
// AXI-Stream master emitting framed ramp patterns with idle gaps,
// full backpressure support and a graceful end-of-frame stop.
module axis_pattern_source
   import axis_src_pkg::*;
#(
   parameter int C_M00_AXIS_TDATA_WIDTH = TDATA_W
) (
   input  logic                              s00_axis_aclk,
   input  logic                              s00_axis_aresetn,
   input  logic                              start,
   input  logic                              stop,
   input  logic [15:0]                       frame_len,
   input  logic [15:0]                       num_frames,
   input  logic [7:0]                        gap_cycles,
   input  logic [31:0]                       seed,
   input  logic [31:0]                       step,
   input  logic                              m00_axis_tready,
   output logic                              m00_axis_tvalid,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
   output logic                              m00_axis_tlast,
   output logic [7:0]                        m00_axis_tstrb,
   output logic                              busy,
   output logic [15:0]                       frames_sent
);

   state_e      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] num_q, num_d;
   logic [7:0]  gap_q, gap_d;
   logic [31:0] step_q, step_d;
   logic [31:0] ramp_q, ramp_d;
   logic [15:0] idx_q, idx_d;
   logic [15:0] frames_q, frames_d;
   logic [7:0]  gcnt_q, gcnt_d;
   logic        stop_q, stop_d;
   logic        hs;
   logic        last;

   assign last = (idx_q == len_q - 16'd1);
   assign hs   = (state_q == SEND) && m00_axis_tready;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      num_d    = num_q;
      gap_d    = gap_q;
      step_d   = step_q;
      ramp_d   = ramp_q;
      idx_d    = idx_q;
      frames_d = frames_q;
      gcnt_d   = gcnt_q;
      stop_d   = stop_q;
      unique case (state_q)
         IDLE: begin
            if (start && frame_len != 16'd0) begin
               len_d    = frame_len;
               num_d    = num_frames;
               gap_d    = gap_cycles;
               step_d   = step;
               ramp_d   = seed;
               idx_d    = 16'd0;
               frames_d = 16'd0;
               stop_d   = 1'b0;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (stop) stop_d = 1'b1;
            if (hs) begin
               ramp_d = ramp_q + step_q;
               idx_d  = idx_q + 16'd1;
               if (last) begin
                  idx_d    = 16'd0;
                  frames_d = frames_q + 16'd1;
                  // A pending stop still lets this frame's tlast go out.
                  if (stop_q || stop ||
                      (num_q != 16'd0 && frames_q + 16'd1 == num_q)) begin
                     state_d = IDLE;
                     stop_d  = 1'b0;
                  end else if (gap_q != 8'd0) begin
                     state_d = GAP;
                     gcnt_d  = gap_q;
                  end
               end
            end
         end
         GAP: begin
            if (stop_q || stop) begin
               state_d = IDLE;
               stop_d  = 1'b0;
            end else if (gcnt_q == 8'd1) begin
               state_d = SEND;
            end else begin
               gcnt_d = gcnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state_q  <= IDLE;
         len_q    <= '0;
         num_q    <= '0;
         gap_q    <= '0;
         step_q   <= '0;
         ramp_q   <= '0;
         idx_q    <= '0;
         frames_q <= '0;
         gcnt_q   <= '0;
         stop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         num_q    <= num_d;
         gap_q    <= gap_d;
         step_q   <= step_d;
         ramp_q   <= ramp_d;
         idx_q    <= idx_d;
         frames_q <= frames_d;
         gcnt_q   <= gcnt_d;
         stop_q   <= stop_d;
      end
   end

   // Outputs decode only flops, so nothing follows tready combinationally.
   assign m00_axis_tvalid                    = (state_q == SEND);
   assign m00_axis_tlast                     = (state_q == SEND) && last;
   assign m00_axis_tdata[IDX_MSB:IDX_LSB]   = {16'd0, idx_q};
   assign m00_axis_tdata[RAMP_MSB:RAMP_LSB] = ramp_q;
   assign m00_axis_tstrb                     = 8'hFF;
   assign busy                               = (state_q != IDLE);
   assign frames_sent                        = frames_q;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Directed-plus-random bench for axis_pattern_source against a closed-form ramp model.
module tb_axis_pattern_source;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop;
   logic [15:0] frame_len, num_frames;
   logic [7:0]  gap_cycles;
   logic [31:0] seed, step;
   logic        tready;
   logic        tvalid, tlast, busy;
   logic [63:0] tdata;
   logic [7:0]  tstrb;
   logic [15:0] frames_sent;

   int passes = 0;
   int total  = 0;

   always #5 clk = ~clk;

   axis_pattern_source #(.C_M00_AXIS_TDATA_WIDTH(64)) dut (
      .s00_axis_aclk   (clk),
      .s00_axis_aresetn(rst_n),
      .start           (start),
      .stop            (stop),
      .frame_len       (frame_len),
      .num_frames      (num_frames),
      .gap_cycles      (gap_cycles),
      .seed            (seed),
      .step            (step),
      .m00_axis_tready (tready),
      .m00_axis_tvalid (tvalid),
      .m00_axis_tdata  (tdata),
      .m00_axis_tlast  (tlast),
      .m00_axis_tstrb  (tstrb),
      .busy            (busy),
      .frames_sent     (frames_sent)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected beats follow from the rules: beat k of the run carries
   // ramp seed+k*step, index k mod len, tlast on index len-1.
   task automatic run(input int len, input int nf, input int gap,
                      input logic [31:0] sd, input logic [31:0] st,
                      input bit rnd, input int stop_at, input bit midstart);
      logic [31:0] er[$];
      logic [31:0] ei[$];
      bit          el[$];
      int          nfr, beat, gcnt, cyc;
      bit          prev_stall, after_last;
      logic [63:0] prev_data;
      logic        prev_last;
      nfr = (nf != 0) ? nf : stop_at / len + 1;
      for (int f = 0; f < nfr; f++)
         for (int i = 0; i < len; i++) begin
            er.push_back(sd + st * 32'(f * len + i));
            ei.push_back(32'(i));
            el.push_back(i == len - 1);
         end
      beat = 0; gcnt = 0; cyc = 0;
      prev_stall = 0; after_last = 0;
      prev_data = '0; prev_last = 0;
      @(negedge clk);
      frame_len  = 16'(len);
      num_frames = 16'(nf);
      gap_cycles = 8'(gap);
      seed       = sd;
      step       = st;
      start      = 1'b1;
      @(negedge clk);
      check("latency_tvalid", tvalid, 1);
      check("start_busy", busy, 1);
      while (er.size() != 0 && cyc < 2000) begin
         if (cyc > 0) @(negedge clk);
         cyc++;
         start  = 1'b0;
         stop   = 1'b0;
         tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (prev_stall) begin
            check("hold_tvalid", tvalid, 1);
            check("hold_tdata", tdata, prev_data);
            check("hold_tlast", tlast, prev_last);
         end
         if (tvalid) begin
            if (after_last) begin
               check("gap_len", 64'(gcnt), 64'(gap));
               after_last = 0;
            end
         end else if (after_last) begin
            gcnt++;
         end
         if (tvalid && tready) begin
            check("tdata", tdata, {er[0], ei[0]});
            check("tlast", tlast, el[0]);
            if (el[0]) begin
               after_last = 1;
               gcnt = 0;
            end
            if (beat == stop_at) stop = 1'b1;
            if (midstart && beat == 2) begin
               start     = 1'b1;
               frame_len = 16'd7;
               seed      = 32'd0;
               step      = 32'd1;
            end
            void'(er.pop_front());
            void'(ei.pop_front());
            void'(el.pop_front());
            beat++;
         end
         prev_stall = tvalid && !tready;
         prev_data  = tdata;
         prev_last  = tlast;
      end
      check("run_done", 64'(er.size()), 0);
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      check("end_tvalid", tvalid, 0);
      check("end_busy", busy, 0);
      check("frames_sent", frames_sent, 64'(nfr));
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0; stop = 1'b0; tready = 1'b1;
      frame_len = '0; num_frames = '0; gap_cycles = '0;
      seed = '0; step = '0;
      repeat (3) @(negedge clk);
      check("rst_tvalid", tvalid, 0);
      check("rst_tlast", tlast, 0);
      check("rst_tdata", tdata, 0);
      check("rst_busy", busy, 0);
      check("rst_frames", frames_sent, 0);
      check("tstrb", tstrb, 8'hFF);
      rst_n = 1'b1;

      run(4, 2, 0, 32'd100, 32'd3, 0, -1, 0);
      run(4, 2, 0, 32'd100, 32'd3, 1, -1, 0);
      run(3, 3, 5, $urandom, $urandom, 0, -1, 1);
      run(4, 0, 2, $urandom, $urandom, 1, 9, 0);

      @(negedge clk);
      frame_len = 16'd0; num_frames = 16'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("len0_tvalid", tvalid, 0);
         check("len0_busy", busy, 0);
         @(negedge clk);
      end

      frame_len = 16'd8; num_frames = 16'd1; gap_cycles = 8'd0;
      seed = 32'h1234; step = 32'd7; tready = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("pre_rst_tvalid", tvalid, 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_tvalid", tvalid, 0);
      check("arst_busy", busy, 0);
      check("arst_tdata", tdata, 0);
      check("arst_frames", frames_sent, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(5, 1, 0, $urandom, $urandom, 0, -1, 0);

      for (int r = 0; r < 4; r++)
         run(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)),
             int'($urandom_range(0, 3)), $urandom, $urandom, 1, -1, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/axis_pattern_source.md
# axis_pattern_source

AXI-Stream master that generates framed test patterns into the CORDIC input stream, the active driving counterpart of the passive stream monitor on the CORDIC output. It emits programmable-length frames of ramp samples, honours downstream backpressure under full AXI-Stream rules, and inserts idle gaps between frames. It is used for bring-up and closed-loop checking of the CORDIC path, together with the output snooper.

## Interface
Parameters:
- C_M00_AXIS_TDATA_WIDTH, 64, stream width; fixed at 64, other values unsupported.

Ports:
- s00_axis_aclk  in  1  sole clock, rising edge.
- s00_axis_aresetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- stop  in  1  one-cycle pulse; ends the run after the current frame.
- frame_len  in  16  beats per frame; latched at start.
- num_frames  in  16  frames per run, latched at start; 0 = continuous until stop.
- gap_cycles  in  8  idle cycles between frames; latched at start.
- seed  in  32  initial ramp value; latched at start.
- step  in  32  ramp increment per accepted beat; latched at start.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tvalid  out  1  beat valid.
- m00_axis_tdata  out  64  [31:0] beat index within frame; [63:32] ramp value.
- m00_axis_tlast  out  1  last beat of frame.
- m00_axis_tstrb  out  8  constant 8'hFF.
- busy  out  1  high in any state other than IDLE.
- frames_sent  out  16  count of completed frames in the current run; wraps at 2^16.

## Operation
- Handshake: a beat transfers when tvalid && tready.
- FSM states and transitions:
  - IDLE to SEND: start=1 and frame_len!=0. Latch parameters; set ramp=seed, beat_idx=0, frames_sent=0.
  - start while frame_len=0: ignored; state stays IDLE.
  - start while not IDLE: ignored.
- SEND:
  - tvalid=1.
  - tdata={ramp, beat_idx}.
  - tlast=(beat_idx==frame_len_q-1).
  - On handshake: ramp+=step (mod 2^32); beat_idx+=1.
- SEND on a tlast handshake:
  - beat_idx=0 and frames_sent+=1.
  - Next state is IDLE if stop is pending, or if num_frames_q!=0 and frames_sent+1==num_frames_q.
  - Otherwise next state is GAP if gap_cycles_q!=0, else SEND with no bubble.
- GAP:
  - tvalid=0.
  - Counts gap_cycles_q cycles, then goes to SEND.
  - Goes to IDLE instead if stop is pending.
- Stop handling:
  - stop in SEND sets stop_pending, which clears on the next IDLE entry.
  - Frames are never truncated. tlast is always delivered.
  - stop in GAP goes to IDLE next cycle.
  - stop in IDLE: no effect.
- Ramp continuity: ramp is not reset between frames. It continues across the whole run.
- start and stop in the same IDLE cycle: start wins, and stop is discarded.

## Timing
- All outputs are registered. Reset values:
  - tvalid=0, tlast=0, tdata=0, busy=0, frames_sent=0.
  - State=IDLE.
  - tstrb is constant 8'hFF.
- Latency: start sampled at cycle N gives tvalid=1 with the first beat at cycle N+1.
- AXI-Stream rules:
  - Once tvalid is asserted, tvalid, tdata and tlast hold steady until the handshake.
  - tvalid never depends combinationally on tready.
  - With continuous tready, throughput is 1 beat/cycle.
- Gap timing: the last beat handshakes at cycle M. tvalid is low for cycles M+1 through M+gap_cycles, and the next frame's first beat appears at M+gap_cycles+1.
- Run end: after the final tlast handshake, tvalid=0 and busy=0 on the next cycle. frames_sent holds its value until the next start.
- Input changes: frame_len and the other latched inputs may change mid-run with no effect.
- Reset mid-frame: all outputs drop to reset values immediately (asynchronous). No partial frame resumes after reset.

## Structure
- Shared package axis_src_pkg:
  - State enum typedef: IDLE, SEND, GAP.
  - localparams for the TDATA width (64), the beat-index field [31:0] and the ramp field [63:32].
- Single flat module; no sub-module is needed.

## Test plan
- frame_len=4, num_frames=2, gap=0, seed=100, step=3, tready=1:
  - 8 consecutive beats, ramp 100,103,...,121.
  - Index 0..3,0..3; tlast on beats 4 and 8.
  - frames_sent=2 and busy=0 one cycle after beat 8.
- Same run with tready toggling on a pseudo-random pattern:
  - tdata and tlast stay stable across stalls.
  - The beat sequence is identical to the previous scenario.
- frame_len=3, gap=5, num_frames=3:
  - Exactly 5 idle tvalid=0 cycles between frames.
  - tlast on each third beat.
- num_frames=0, frame_len=4, stop pulsed on the 2nd beat of frame 3:
  - Frame 3 completes with tlast.
  - IDLE follows; frames_sent=3.
- start with frame_len=0, and start pulsed mid-run: both ignored.
  - Respectively: tvalid stays 0; the current run's output is unchanged.
- aresetn asserted mid-frame with tready=0:
  - tvalid and busy drop immediately.
  - After release plus start, the new run begins at index 0 with ramp=seed.
